cfg_connection_block: RTL and testbench
=======================================

Name: cfg_connection_block

Overview:
- Unidirectional, synthesizable successor to the tran-based connection block: every switch point is a mux, not a bidirectional pass gate.
- Routing configuration is held in an internal active register, loaded through a word-wide valid/ready stream into a shadow register, then committed atomically.
- Sits between two CLBs and one routing channel. Connects track/global/neighbour signals to CLB input pins. Lets CLB outputs override tracks.

Parameters:
- WS, 8, single-length tracks
- WD, 8, double-length tracks
- WG, 3, global lines
- CLBIN0, 6, CLB0 input pins
- CLBIN1, 6, CLB1 input pins
- CLBOUT0, 1, CLB0 outputs
- CLBOUT1, 1, CLB1 outputs
- CARRY0TO1, 1, carry lines CLB0→CLB1
- CARRY1TO0, 1, carry lines CLB1→CLB0
- CLBX, 1, 1 = each CLB's input muxes also see the other CLB's outputs
- CW, 8, config stream word width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config beat valid
- cfg_ready  out  1  config beat accepted when valid&ready
- cfg_data  in  CW  config beat
- cfg_last  in  1  final beat marker
- cfg_done  out  1  one-cycle pulse: new config live
- cfg_err  out  1  one-cycle pulse: framing error
- single_in / single_out  in/out  WS  channel single tracks
- double_in / double_out  in/out  WD  channel double tracks
- global0  in  WG  globals
- clb0_output  in  CLBOUT0
- clb1_output  in  CLBOUT1
- clb0_cout  in  CARRY0TO1
- clb1_cout  in  CARRY1TO0
- clb0_input  out  CLBIN0
- clb1_input  out  CLBIN1
- clb0_cin  out  CARRY1TO0
- clb1_cin  out  CARRY0TO1

Behaviour:
- Widths and config size:
  - SRC0 = WS+WD+WG+CLBX*CLBOUT1; SRC1 = WS+WD+WG+CLBX*CLBOUT0; DSRC = CLBOUT0+CLBOUT1.
  - SELWk = clog2(SRCk+1); DSELW = clog2(DSRC+1).
  - TOTAL = CLBIN0*SEL0 + CLBIN1*SEL1 + (WS+WD)*DSELW; NBEATS = ceil(TOTAL/CW).
  - Defaults: SEL=5, DSELW=2, TOTAL=92, NBEATS=12.
- Config vector layout, LSB first:
  - CLB0 pin selects, pin 0 lowest.
  - CLB1 pin selects.
  - Single-track driver selects.
  - Double-track driver selects.
- Pin mux semantics:
  - Select 0 → pin = 0.
  - Select k in 1..SRC → source k-1.
  - Source order: single_in, double_in, global0, other CLB outputs.
  - Select > SRC → 0.
- Track driver semantics:
  - Select 0 → out = in (pass-through).
  - Select k → clbN output (CLB0 outputs first).
  - Select > DSRC → pass-through.
- Routing and carry paths are combinational from the active register; carries pass straight through.
- Stream framing: beat b fills vector bits [b*CW +: CW]; pad bits of the final beat are ignored.
- FSM states: IDLE, LOAD, COMMIT, DRAIN.
  - IDLE/LOAD: cfg_ready=1. Each accepted beat is written to shadow and the beat counter increments.
  - Accept index NBEATS-1 with last=1 → COMMIT.
  - last=1 at index < NBEATS-1 → cfg_err, shadow discarded, → IDLE.
  - Index NBEATS-1 with last=0 → cfg_err → DRAIN.
  - COMMIT: cfg_ready=0; active ← shadow; → IDLE.
  - DRAIN: cfg_ready=1; beats discarded until a beat with last=1 is accepted → IDLE.
- Timing:
  - Last beat accepted in cycle N; COMMIT in cycle N+1.
  - New routing and cfg_done pulse both in cycle N+2.
  - cfg_err is a registered pulse in the cycle after the offending beat.
- Active config changes only on COMMIT; a failed load never alters routing.
- Reset:
  - Outputs: cfg_ready=1, cfg_done=0, cfg_err=0.
  - Active = 0: all pins 0, all tracks pass through.
  - Shadow and counter cleared; state IDLE.
  - Reset mid-load aborts the load without an error pulse.

Decomposition:
- Package cb_cfg_pkg holds:
  - FSM state enum.
  - clog2 function.
  - Layout offset functions: pin select offset, track select offset.
- Sub-module cb_cfg_loader holds FSM, beat counter, shadow, active, done/err. Parameterised by TOTAL and CW; outputs the active vector.
- The top level instantiates cb_cfg_loader plus generate-loop muxes.

Test Plan:
- Reset → cfg_ready=1. Random single_in/clb outputs → all clb inputs 0 and single_out==single_in.
- Load 12 beats, beat0=8'h01, beat8=8'h04, others 0, last on beat 11:
  - cfg_done pulses 2 cycles after the last beat.
  - clb0_input[0] follows single_in[0].
  - single_out[3] follows clb0_output[0]; all other tracks pass through.
- Early last on beat 4 → cfg_err pulse, no cfg_done, routing unchanged from the previous test.
- 12 beats with last=0, then 3 further beats, last on the third → cfg_err after beat 11, cfg_ready held 1 while draining, routing unchanged, then IDLE.
- cfg_valid held high continuously → cfg_ready=0 for exactly the COMMIT cycle, no beat lost. A back-to-back second load commits correctly.
- rst asserted after beat 6 → next cycle active=0, cfg_ready=1, no err. A subsequent full load succeeds.

Source files
------------

// File: rtl/cb_cfg_pkg.sv
// Shared types and layout helpers for the configurable connection block.
// Offsets locate each select field inside the flat LSB-first config vector.
package cb_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_DRAIN
  } cfg_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // CLB0 selects come first, CLB1 selects follow them.
  function automatic int unsigned pin_sel_off(input int unsigned clb, input int unsigned pin,
                                              input int unsigned nin0, input int unsigned sel0,
                                              input int unsigned sel1);
    return (clb == 0) ? pin * sel0 : nin0 * sel0 + pin * sel1;
  endfunction

  // Track index counts singles first, then doubles.
  function automatic int unsigned trk_sel_off(input int unsigned trk, input int unsigned base,
                                              input int unsigned dselw);
    return base + trk * dselw;
  endfunction

endpackage

// File: rtl/cb_cfg_loader.sv
// Config stream loader: beats fill a shadow register, which is committed
// atomically into the active routing vector after a correctly framed load.
module cb_cfg_loader
  import cb_cfg_pkg::*;
#(
  parameter int unsigned TOTAL = 92,
  parameter int unsigned CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [CW-1:0]    i_data,
  input  logic             i_last,
  output logic             o_done,
  output logic             o_err,
  output logic [TOTAL-1:0] o_active
);

  localparam int unsigned NBEATS = (TOTAL + CW - 1) / CW;
  localparam int unsigned CNTW   = (clog2(NBEATS) > 0) ? clog2(NBEATS) : 1;
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NBEATS - 1);

  cfg_state_e       r_state, w_next;
  logic [CNTW-1:0]  r_cnt;
  logic [TOTAL-1:0] r_shadow, r_active, w_shadow_wr;
  logic             r_done, r_err;
  logic             w_beat_wr, w_commit, w_set_err, w_cnt_clr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_ready   = 1'b1;
    w_beat_wr = 1'b0;
    w_commit  = 1'b0;
    w_set_err = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (i_valid) begin
          w_beat_wr = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_cnt_clr = 1'b1;
            if (i_last) begin
              w_next = ST_COMMIT;
            end else begin
              w_set_err = 1'b1;
              w_next    = ST_DRAIN;
            end
          end else if (i_last) begin
            w_cnt_clr = 1'b1;
            w_set_err = 1'b1;
            w_next    = ST_IDLE;
          end else begin
            w_next = ST_LOAD;
          end
        end
      end
      ST_COMMIT: begin
        o_ready  = 1'b0;
        w_commit = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_DRAIN: begin
        if (i_valid && i_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-bit merge so pad bits of the final beat never reach the vector.
  always_comb begin
    w_shadow_wr = r_shadow;
    for (int unsigned k = 0; k < TOTAL; k++) begin
      if (r_cnt == CNTW'(k / CW)) w_shadow_wr[k] = i_data[k % CW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_commit;
      r_err  <= w_set_err;
      if (w_beat_wr) r_shadow <= w_shadow_wr;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_beat_wr) r_cnt <= r_cnt + CNTW'(1);
      if (w_commit) r_active <= r_shadow;
    end
  end

  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_active = r_active;

endmodule

// File: rtl/cfg_connection_block.sv
// Mux-based connection block between two CLBs and one routing channel; the
// routing is driven from the loader's committed active config vector.
module cfg_connection_block
  import cb_cfg_pkg::*;
#(
  parameter int unsigned WS        = 8,
  parameter int unsigned WD        = 8,
  parameter int unsigned WG        = 3,
  parameter int unsigned CLBIN0    = 6,
  parameter int unsigned CLBIN1    = 6,
  parameter int unsigned CLBOUT0   = 1,
  parameter int unsigned CLBOUT1   = 1,
  parameter int unsigned CARRY0TO1 = 1,
  parameter int unsigned CARRY1TO0 = 1,
  parameter int unsigned CLBX      = 1,
  parameter int unsigned CW        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CW-1:0]        cfg_data,
  input  logic                 cfg_last,
  output logic                 cfg_done,
  output logic                 cfg_err,
  input  logic [WS-1:0]        single_in,
  output logic [WS-1:0]        single_out,
  input  logic [WD-1:0]        double_in,
  output logic [WD-1:0]        double_out,
  input  logic [WG-1:0]        global0,
  input  logic [CLBOUT0-1:0]   clb0_output,
  input  logic [CLBOUT1-1:0]   clb1_output,
  input  logic [CARRY0TO1-1:0] clb0_cout,
  input  logic [CARRY1TO0-1:0] clb1_cout,
  output logic [CLBIN0-1:0]    clb0_input,
  output logic [CLBIN1-1:0]    clb1_input,
  output logic [CARRY1TO0-1:0] clb0_cin,
  output logic [CARRY0TO1-1:0] clb1_cin
);

  localparam int unsigned SRC0     = WS + WD + WG + CLBX * CLBOUT1;
  localparam int unsigned SRC1     = WS + WD + WG + CLBX * CLBOUT0;
  localparam int unsigned DSRC     = CLBOUT0 + CLBOUT1;
  localparam int unsigned SEL0     = clog2(SRC0 + 1);
  localparam int unsigned SEL1     = clog2(SRC1 + 1);
  localparam int unsigned DSELW    = clog2(DSRC + 1);
  localparam int unsigned TRK_BASE = CLBIN0 * SEL0 + CLBIN1 * SEL1;
  localparam int unsigned TOTAL    = TRK_BASE + (WS + WD) * DSELW;

  localparam logic [SEL0-1:0]  SRC0_L = SEL0'(SRC0);
  localparam logic [SEL1-1:0]  SRC1_L = SEL1'(SRC1);
  localparam logic [DSELW-1:0] DSRC_L = DSELW'(DSRC);

  logic [TOTAL-1:0] w_active;
  logic [SRC0-1:0]  w_src0;
  logic [SRC1-1:0]  w_src1;
  logic [DSRC-1:0]  w_dsrc;

  cb_cfg_loader #(
    .TOTAL(TOTAL),
    .CW   (CW)
  ) u_loader (
    .clk     (clk),
    .rst     (rst),
    .i_valid (cfg_valid),
    .o_ready (cfg_ready),
    .i_data  (cfg_data),
    .i_last  (cfg_last),
    .o_done  (cfg_done),
    .o_err   (cfg_err),
    .o_active(w_active)
  );

  always_comb begin
    w_src0 = '0;
    w_src1 = '0;
    for (int unsigned i = 0; i < WS; i++) begin
      w_src0[i] = single_in[i];
      w_src1[i] = single_in[i];
    end
    for (int unsigned i = 0; i < WD; i++) begin
      w_src0[WS+i] = double_in[i];
      w_src1[WS+i] = double_in[i];
    end
    for (int unsigned i = 0; i < WG; i++) begin
      w_src0[WS+WD+i] = global0[i];
      w_src1[WS+WD+i] = global0[i];
    end
    for (int unsigned i = 0; i < CLBX * CLBOUT1; i++) w_src0[WS+WD+WG+i] = clb1_output[i];
    for (int unsigned i = 0; i < CLBX * CLBOUT0; i++) w_src1[WS+WD+WG+i] = clb0_output[i];
  end

  assign w_dsrc = {clb1_output, clb0_output};

  for (genvar p = 0; p < CLBIN0; p++) begin : g_pin0
    localparam int unsigned OFF = pin_sel_off(0, p, CLBIN0, SEL0, SEL1);
    logic [SEL0-1:0] w_sel;
    assign w_sel = w_active[OFF +: SEL0];
    assign clb0_input[p] = (w_sel != '0 && w_sel <= SRC0_L) ? w_src0[w_sel - 1'b1] : 1'b0;
  end

  for (genvar p = 0; p < CLBIN1; p++) begin : g_pin1
    localparam int unsigned OFF = pin_sel_off(1, p, CLBIN0, SEL0, SEL1);
    logic [SEL1-1:0] w_sel;
    assign w_sel = w_active[OFF +: SEL1];
    assign clb1_input[p] = (w_sel != '0 && w_sel <= SRC1_L) ? w_src1[w_sel - 1'b1] : 1'b0;
  end

  for (genvar t = 0; t < WS; t++) begin : g_single
    localparam int unsigned OFF = trk_sel_off(t, TRK_BASE, DSELW);
    logic [DSELW-1:0] w_sel;
    assign w_sel = w_active[OFF +: DSELW];
    assign single_out[t] = (w_sel != '0 && w_sel <= DSRC_L) ? w_dsrc[w_sel - 1'b1] : single_in[t];
  end

  for (genvar t = 0; t < WD; t++) begin : g_double
    localparam int unsigned OFF = trk_sel_off(WS + t, TRK_BASE, DSELW);
    logic [DSELW-1:0] w_sel;
    assign w_sel = w_active[OFF +: DSELW];
    assign double_out[t] = (w_sel != '0 && w_sel <= DSRC_L) ? w_dsrc[w_sel - 1'b1] : double_in[t];
  end

  assign clb1_cin = clb0_cout;
  assign clb0_cin = clb1_cout;

endmodule

// File: tb/tb_cfg_connection_block.sv
// Directed bench for cfg_connection_block: reset, load/commit timing, framing
// errors, drain, back-to-back loads and reset during a load.
module tb_cfg_connection_block;

  logic       clk, rst;
  logic       cfg_valid, cfg_ready, cfg_last, cfg_done, cfg_err;
  logic [7:0] cfg_data;
  logic [7:0] single_in, single_out, double_in, double_out;
  logic [2:0] global0;
  logic       clb0_output, clb1_output, clb0_cout, clb1_cout, clb0_cin, clb1_cin;
  logic [5:0] clb0_input, clb1_input;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0][7:0] cfg_a, cfg_b, cfg_c;

  cfg_connection_block #(
    .WS(8), .WD(8), .WG(3), .CLBIN0(6), .CLBIN1(6), .CLBOUT0(1), .CLBOUT1(1),
    .CARRY0TO1(1), .CARRY1TO0(1), .CLBX(1), .CW(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .single_in(single_in), .single_out(single_out),
    .double_in(double_in), .double_out(double_out),
    .global0(global0), .clb0_output(clb0_output), .clb1_output(clb1_output),
    .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
    .clb0_input(clb0_input), .clb1_input(clb1_input),
    .clb0_cin(clb0_cin), .clb1_cin(clb1_cin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_io(input logic [7:0] s, input logic [7:0] d, input logic [2:0] g,
                        input logic o0, input logic o1);
    single_in = s; double_in = d; global0 = g;
    clb0_output = o0; clb1_output = o1; clb0_cout = o0; clb1_cout = o1;
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, output int stalls);
    cfg_valid = 1'b1; cfg_data = d; cfg_last = l; stalls = 0;
    while (!cfg_ready && stalls < 8) begin
      tick();
      stalls++;
    end
    if (!cfg_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept_timeout: cfg_ready got %b want 1 within 8 cycles", cfg_ready);
    end
    tick();
  endtask

  task automatic load_cfg(input logic [11:0][7:0] c);
    int st;
    for (int b = 0; b < 12; b++) send_beat(c[b], b == 11, st);
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    set_io(8'h5A, 8'hC3, 3'b110, 1'b1, 1'b1);
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    n_cmp++; if (clb0_input !== 6'h00) begin n_bad++; $display("FAIL reset_clb0_in: got %h want 00", clb0_input); end
    n_cmp++; if (clb1_input !== 6'h00) begin n_bad++; $display("FAIL reset_clb1_in: got %h want 00", clb1_input); end
    n_cmp++; if (single_out !== 8'h5A) begin n_bad++; $display("FAIL reset_single: got %h want 5a", single_out); end
    n_cmp++; if (double_out !== 8'hC3) begin n_bad++; $display("FAIL reset_double: got %h want c3", double_out); end
    n_cmp++; if (clb1_cin !== 1'b1) begin n_bad++; $display("FAIL reset_carry01: got %b want 1", clb1_cin); end
    set_io(8'hA7, 8'h19, 3'b011, 1'b1, 1'b0);
    n_cmp++; if (single_out !== 8'hA7) begin n_bad++; $display("FAIL reset_single2: got %h want a7", single_out); end
    n_cmp++; if (clb0_input !== 6'h00) begin n_bad++; $display("FAIL reset_clb0_in2: got %h want 00", clb0_input); end
    n_cmp++; if (clb0_cin !== 1'b0) begin n_bad++; $display("FAIL reset_carry10: got %b want 0", clb0_cin); end
  endtask

  task automatic test_load_a();
    set_io(8'h01, 8'h00, 3'b000, 1'b1, 1'b0);
    load_cfg(cfg_a);
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL loada_commit_ready: got %b want 0", cfg_ready); end
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL loada_early_done: got %b want 0", cfg_done); end
    n_cmp++; if (clb0_input !== 6'h00) begin n_bad++; $display("FAIL loada_early_route: got %h want 00", clb0_input); end
    tick();
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL loada_done: got %b want 1", cfg_done); end
    n_cmp++; if (clb0_input !== 6'h01) begin n_bad++; $display("FAIL loada_pin0: got %h want 01", clb0_input); end
    n_cmp++; if (single_out !== 8'h09) begin n_bad++; $display("FAIL loada_track3: got %h want 09", single_out); end
    tick();
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL loada_done_pulse: got %b want 0", cfg_done); end
    set_io(8'hFE, 8'h55, 3'b111, 1'b0, 1'b1);
    n_cmp++; if (clb0_input !== 6'h00) begin n_bad++; $display("FAIL loada_pin0_lo: got %h want 00", clb0_input); end
    n_cmp++; if (single_out !== 8'hF6) begin n_bad++; $display("FAIL loada_track3_lo: got %h want f6", single_out); end
    n_cmp++; if (double_out !== 8'h55) begin n_bad++; $display("FAIL loada_double: got %h want 55", double_out); end
    n_cmp++; if (clb1_input !== 6'h00) begin n_bad++; $display("FAIL loada_clb1: got %h want 00", clb1_input); end
  endtask

  task automatic test_early_last();
    int st;
    set_io(8'h01, 8'h00, 3'b000, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) send_beat(8'hFF, 1'b0, st);
    send_beat(8'hFF, 1'b1, st);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL early_err: got %b want 1", cfg_err); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL early_ready: got %b want 1", cfg_ready); end
    tick();
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL early_err_pulse: got %b want 0", cfg_err); end
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL early_done1: got %b want 0", cfg_done); end
    tick();
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL early_done2: got %b want 0", cfg_done); end
    n_cmp++; if (clb0_input !== 6'h01) begin n_bad++; $display("FAIL early_route: got %h want 01", clb0_input); end
    n_cmp++; if (single_out !== 8'h01) begin n_bad++; $display("FAIL early_track: got %h want 01", single_out); end
  endtask

  task automatic test_drain();
    int st;
    for (int b = 0; b < 12; b++) send_beat(8'hFF, 1'b0, st);
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL drain_err: got %b want 1", cfg_err); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready: got %b want 1", cfg_ready); end
    send_beat(8'hFF, 1'b0, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL drain_stall1: got %0d want 0", st); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL drain_err_pulse: got %b want 0", cfg_err); end
    send_beat(8'hFF, 1'b0, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL drain_stall2: got %0d want 0", st); end
    send_beat(8'hFF, 1'b1, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL drain_stall3: got %0d want 0", st); end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL drain_done1: got %b want 0", cfg_done); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL drain_idle_ready: got %b want 1", cfg_ready); end
    tick();
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL drain_done2: got %b want 0", cfg_done); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL drain_err_end: got %b want 0", cfg_err); end
    n_cmp++; if (clb0_input !== 6'h01) begin n_bad++; $display("FAIL drain_route: got %h want 01", clb0_input); end
  endtask

  task automatic test_back_to_back();
    int st, tot;
    set_io(8'hA5, 8'h3C, 3'b101, 1'b1, 1'b1);
    tot = 0;
    for (int b = 0; b < 12; b++) begin
      send_beat(cfg_b[b], b == 11, st);
      tot += st;
    end
    n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL b2b_stalls_b: got %0d want 0", tot); end
    cfg_data = cfg_c[0]; cfg_last = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_commit_ready: got %b want 0", cfg_ready); end
    tick();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_back: got %b want 1", cfg_ready); end
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_b: got %b want 1", cfg_done); end
    n_cmp++; if (clb1_input !== 6'h01) begin n_bad++; $display("FAIL b2b_clb1_pin0: got %h want 01", clb1_input); end
    n_cmp++; if (clb0_input !== 6'h00) begin n_bad++; $display("FAIL b2b_clb0_b: got %h want 00", clb0_input); end
    n_cmp++; if (double_out !== 8'h3D) begin n_bad++; $display("FAIL b2b_double0: got %h want 3d", double_out); end
    n_cmp++; if (single_out !== 8'hA5) begin n_bad++; $display("FAIL b2b_single_b: got %h want a5", single_out); end
    tick();
    tot = 0;
    for (int b = 1; b < 12; b++) begin
      send_beat(cfg_c[b], b == 11, st);
      tot += st;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL b2b_stalls_c: got %0d want 0", tot); end
    set_io(8'hA5, 8'h3C, 3'b101, 1'b0, 1'b0);
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL b2b_early_done_c: got %b want 0", cfg_done); end
    tick();
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_c: got %b want 1", cfg_done); end
    n_cmp++; if (clb0_input !== 6'h20) begin n_bad++; $display("FAIL b2b_clb0_c: got %h want 20", clb0_input); end
    n_cmp++; if (clb1_input !== 6'h00) begin n_bad++; $display("FAIL b2b_clb1_c: got %h want 00", clb1_input); end
    n_cmp++; if (single_out !== 8'hA5) begin n_bad++; $display("FAIL b2b_single_c: got %h want a5", single_out); end
    n_cmp++; if (double_out !== 8'h3C) begin n_bad++; $display("FAIL b2b_double_c: got %h want 3c", double_out); end
    set_io(8'h5A, 8'h3C, 3'b010, 1'b1, 1'b1);
    n_cmp++; if (clb0_input !== 6'h00) begin n_bad++; $display("FAIL b2b_clb0_c2: got %h want 00", clb0_input); end
    n_cmp++; if (single_out !== 8'h5A) begin n_bad++; $display("FAIL b2b_single_c2: got %h want 5a", single_out); end
  endtask

  task automatic test_reset_mid_load();
    int st;
    set_io(8'h01, 8'hF0, 3'b001, 1'b1, 1'b0);
    for (int b = 0; b < 7; b++) send_beat(cfg_a[b], 1'b0, st);
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", cfg_ready); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", cfg_err); end
    n_cmp++; if (clb0_input !== 6'h00) begin n_bad++; $display("FAIL midrst_clb0: got %h want 00", clb0_input); end
    n_cmp++; if (single_out !== 8'h01) begin n_bad++; $display("FAIL midrst_single: got %h want 01", single_out); end
    n_cmp++; if (double_out !== 8'hF0) begin n_bad++; $display("FAIL midrst_double: got %h want f0", double_out); end
    tick();
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err2: got %b want 0", cfg_err); end
    load_cfg(cfg_a);
    tick();
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL midrst_done: got %b want 1", cfg_done); end
    n_cmp++; if (clb0_input !== 6'h01) begin n_bad++; $display("FAIL midrst_pin0: got %h want 01", clb0_input); end
    n_cmp++; if (single_out !== 8'h09) begin n_bad++; $display("FAIL midrst_track3: got %h want 09", single_out); end
  endtask

  initial begin
    cfg_a = '0; cfg_a[0] = 8'h01; cfg_a[8] = 8'h04;
    cfg_b = '0; cfg_b[4] = 8'h05; cfg_b[9] = 8'h20;
    cfg_c = '0; cfg_c[0] = 8'hE0; cfg_c[1] = 8'h03; cfg_c[3] = 8'h22; cfg_c[9] = 8'h0C;
    rst = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    single_in = '0; double_in = '0; global0 = '0;
    clb0_output = 1'b0; clb1_output = 1'b0; clb0_cout = 1'b0; clb1_cout = 1'b0;
    test_reset();
    test_load_a();
    test_early_last();
    test_drain();
    test_back_to_back();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
